// File: rtl/reg_write_arbiter_if.sv
// Write-request bus between the requester agents and reg_write_arbiter, plus
// the enable/data pins the arbiter drives into the register bank.
//   req      requester -> arbiter   one request bit per requester
//   wr_addr  requester -> arbiter   lane i = [i*AW +: AW]
//   wr_data  requester -> arbiter   lane i = [i*SIZE +: SIZE]
//   gnt      arbiter -> requester   one-cycle ack to the served requester
//   reg_ena  arbiter -> bank        one-hot write enable
//   reg_d    arbiter -> bank        shared data bus
//   busy     arbiter -> observers   high while a write is in flight
//   err      arbiter -> observers   pulse when the served address is out of range
interface reg_write_arbiter_if #(
   parameter int SIZE = 4,
   parameter int NREQ = 4,
   parameter int NREG = 8,
   parameter int AW   = 3
);
   logic [NREQ-1:0]      req;
   logic [NREQ*AW-1:0]   wr_addr;
   logic [NREQ*SIZE-1:0] wr_data;
   logic [NREQ-1:0]      gnt;
   logic [NREG-1:0]      reg_ena;
   logic [SIZE-1:0]      reg_d;
   logic                 busy;
   logic                 err;

   modport master (
      output req, wr_addr, wr_data,
      input  gnt, reg_ena, reg_d, busy, err
   );

   modport slave (
      input  req, wr_addr, wr_data,
      output gnt, reg_ena, reg_d, busy, err
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing a register bank between NREQ write requesters.
// One write is issued per two cycles at most; every output is registered.
//   clk    clock, rising edge
//   rst_n  asynchronous reset, active low
//   bus    reg_write_arbiter_if.slave (requests in; gnt/reg_ena/reg_d/busy/err out)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting; a pending request is granted at the next edge
// WRITE | reg_ena/gnt pulse live this cycle; next edge returns to IDLE
module reg_write_arbiter #(
   parameter int SIZE = 4,
   parameter int NREQ = 4,
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input logic               clk,
   input logic               rst_n,
   reg_write_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, WRITE} state_t;

   state_t          state, state_n;
   logic [PW-1:0]   ptr, ptr_n;
   logic [PW-1:0]   win_q, win_n;
   logic [NREQ-1:0] gnt_q, gnt_n;
   logic [NREG-1:0] ena_q, ena_n;
   logic [SIZE-1:0] d_q, d_n;
   logic            busy_q, busy_n;
   logic            err_q, err_n;

   logic            found;
   logic [PW-1:0]   win;
   logic [AW-1:0]   lane_addr;
   logic [SIZE-1:0] lane_data;

   // Search starts at ptr and wraps, so the last winner gets lowest priority.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % NREQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
      lane_addr = bus.wr_addr[int'(win)*AW +: AW];
      lane_data = bus.wr_data[int'(win)*SIZE +: SIZE];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      win_n   = win_q;
      gnt_n   = '0;
      ena_n   = '0;
      d_n     = d_q;
      busy_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_n    = WRITE;
               win_n      = win;
               gnt_n[win] = 1'b1;
               d_n        = lane_data;
               busy_n     = 1'b1;
               if (int'(lane_addr) < NREG) begin
                  ena_n[lane_addr] = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         WRITE: begin
            // req is deliberately ignored here; the write was latched on entry.
            state_n = IDLE;
            ptr_n   = (int'(win_q) == NREQ-1) ? '0 : win_q + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr    <= '0;
         win_q  <= '0;
         gnt_q  <= '0;
         ena_q  <= '0;
         d_q    <= '0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         ptr    <= ptr_n;
         win_q  <= win_n;
         gnt_q  <= gnt_n;
         ena_q  <= ena_n;
         d_q    <= d_n;
         busy_q <= busy_n;
         err_q  <= err_n;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.reg_ena = ena_q;
   assign bus.reg_d   = d_q;
   assign bus.busy    = busy_q;
   assign bus.err     = err_q;
endmodule
